// File: rtl/branch_update_ctrl_pkg.sv
// Shared definitions for the branch resolution / redirect controller.
// Holds default widths, the FSM encoding and a small decision helper.
package bp_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } bp_state_e;

   // Plain-vector aliases so the state register stays a simple logic vector
   localparam logic [1:0] ST_IDLE     = IDLE;
   localparam logic [1:0] ST_REDIRECT = REDIRECT;
   localparam logic [1:0] ST_FLUSH    = FLUSH;

   function automatic logic is_mispred(input logic pred, input logic taken);
      return pred ^ taken;
   endfunction

endpackage

// File: rtl/branch_update_ctrl_if.sv
// Branch-resolution bus between the EX stage, the predictor and fetch.
// The controller sits on the slave side; the pipeline drives the master side.
interface branch_update_ctrl_if
   import bp_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) ();

   logic            br_valid_i;
   logic            br_taken_i;
   logic            br_pred_i;
   logic            stall_i;
   logic [XLEN-1:0] ttarget_i;
   logic [XLEN-1:0] nttarget_i;
   logic            bp_update_o;
   logic            bp_actual_o;
   logic            pc_redirect_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            flush_o;
   logic            busy_o;

   modport slave (
      input  br_valid_i, br_taken_i, br_pred_i, stall_i, ttarget_i, nttarget_i,
      output bp_update_o, bp_actual_o, pc_redirect_o, redirect_pc_o, flush_o, busy_o
   );

   modport master (
      output br_valid_i, br_taken_i, br_pred_i, stall_i, ttarget_i, nttarget_i,
      input  bp_update_o, bp_actual_o, pc_redirect_o, redirect_pc_o, flush_o, busy_o
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter
   import bp_pkg::*;
#(
   parameter int WIDTH = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_reg;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (inc && (cnt_reg != '1)) begin
         cnt_reg <= cnt_reg + ONE;
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/branch_update_ctrl.sv
// Resolves conditional branches from EX: one predictor update per accepted
// branch, and a REDIRECT -> FLUSH sequence when the prediction was wrong.
module branch_update_ctrl
   import bp_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_cnt_i,
   branch_update_ctrl_if.slave bus,
   output logic [CNT_W-1:0]    branch_cnt_o,
   output logic [CNT_W-1:0]    mispred_cnt_o
);

   logic [1:0]      state_reg;
   logic            bp_update_reg;
   logic            bp_actual_reg;
   logic            pc_redirect_reg;
   logic            flush_reg;
   logic            busy_reg;
   logic [XLEN-1:0] redirect_pc_reg;

   logic            accept;
   logic            mispred;
   logic            go_redirect;
   logic [XLEN-1:0] target;

   // A stalled branch stays in EX and is presented again, so it is not taken here
   assign accept      = (state_reg == ST_IDLE) && bus.br_valid_i && !bus.stall_i;
   assign mispred     = is_mispred(bus.br_pred_i, bus.br_taken_i);
   assign go_redirect = accept && mispred;
   assign target      = bus.br_taken_i ? bus.ttarget_i : bus.nttarget_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg       <= ST_IDLE;
         bp_update_reg   <= 1'b0;
         bp_actual_reg   <= 1'b0;
         pc_redirect_reg <= 1'b0;
         flush_reg       <= 1'b0;
         busy_reg        <= 1'b0;
         redirect_pc_reg <= '0;
      end else begin
         bp_update_reg <= accept;
         bp_actual_reg <= accept & bus.br_taken_i;
         case (state_reg)
            ST_REDIRECT: begin
               // Fetch must keep seeing the corrected PC until the stall clears
               if (!bus.stall_i) begin
                  state_reg       <= ST_FLUSH;
                  pc_redirect_reg <= 1'b0;
                  redirect_pc_reg <= '0;
               end
            end
            ST_FLUSH: begin
               state_reg <= ST_IDLE;
               flush_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg       <= go_redirect ? ST_REDIRECT : ST_IDLE;
               pc_redirect_reg <= go_redirect;
               flush_reg       <= go_redirect;
               busy_reg        <= go_redirect;
               redirect_pc_reg <= go_redirect ? target : '0;
            end
         endcase
      end
   end

   assign bus.bp_update_o   = bp_update_reg;
   assign bus.bp_actual_o   = bp_actual_reg;
   assign bus.pc_redirect_o = pc_redirect_reg;
   assign bus.redirect_pc_o = redirect_pc_reg;
   assign bus.flush_o       = flush_reg;
   assign bus.busy_o        = busy_reg;

   // Index 0 counts every accepted branch, index 1 only the mispredicted ones
   logic [1:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_val [2];

   assign cnt_inc = {go_redirect, accept};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         sat_counter #(.WIDTH(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc   (cnt_inc[gi]),
            .clr   (clr_cnt_i),
            .cnt   (cnt_val[gi])
         );
      end
   endgenerate

   assign branch_cnt_o  = cnt_val[0];
   assign mispred_cnt_o = cnt_val[1];

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Directed bench for branch_update_ctrl; predictor updates are scoreboarded.
module tb_branch_update_ctrl;

   localparam int XLEN  = 32;
   // Narrow counters keep the saturation run short; all-ones is the boundary either way
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   logic clr_cnt_i = 1'b0;
   logic [CNT_W-1:0] branch_cnt_o;
   logic [CNT_W-1:0] mispred_cnt_o;

   branch_update_ctrl_if #(.XLEN(XLEN)) bus ();

   branch_update_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .clr_cnt_i     (clr_cnt_i),
      .bus           (bus),
      .branch_cnt_o  (branch_cnt_o),
      .mispred_cnt_o (mispred_cnt_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic sb_q[$];
   int exp_br  = 0;
   int exp_mis = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Every update pulse must match the oldest accepted branch
   always @(negedge clk) begin
      if (rst_i && bus.bp_update_o === 1'b1) begin
         chk("sb_pending", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) chk("sb_actual", 64'(bus.bp_actual_o), 64'(sb_q.pop_front()));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int v);
      return (v > int'(CNT_MAX)) ? int'(CNT_MAX) : v;
   endfunction

   // Drive one branch that the DUT will accept at the next edge
   task automatic drive_branch(input logic pred, input logic taken,
                               input logic [XLEN-1:0] tt, input logic [XLEN-1:0] nt);
      bus.br_valid_i = 1'b1;
      bus.br_pred_i  = pred;
      bus.br_taken_i = taken;
      bus.ttarget_i  = tt;
      bus.nttarget_i = nt;
      sb_q.push_back(taken);
      exp_br  = sat(exp_br + 1);
      if (pred != taken) exp_mis = sat(exp_mis + 1);
   endtask

   task automatic chk_cnts(input string tag);
      chk({tag, "_br_cnt"},  64'(branch_cnt_o),  64'(exp_br));
      chk({tag, "_mis_cnt"}, 64'(mispred_cnt_o), 64'(exp_mis));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_redir"}, 64'(bus.pc_redirect_o), 64'd0);
      chk({tag, "_rpc"},   64'(bus.redirect_pc_o),  64'd0);
      chk({tag, "_flush"}, 64'(bus.flush_o),        64'd0);
      chk({tag, "_busy"},  64'(bus.busy_o),         64'd0);
   endtask

   initial begin
      bus.br_valid_i = 1'b0;
      bus.br_taken_i = 1'b0;
      bus.br_pred_i  = 1'b0;
      bus.stall_i    = 1'b0;
      bus.ttarget_i  = '0;
      bus.nttarget_i = '0;

      // Reset state
      cyc();
      cyc();
      chk_idle("rst");
      chk("rst_upd", 64'(bus.bp_update_o), 64'd0);
      chk_cnts("rst");

      // Correct prediction on the first edge after reset release
      rst_i = 1'b1;
      drive_branch(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0104);
      cyc();
      bus.br_valid_i = 1'b0;
      chk("ok_upd", 64'(bus.bp_update_o), 64'd1);
      chk("ok_act", 64'(bus.bp_actual_o), 64'd1);
      chk_idle("ok");
      chk_cnts("ok");
      $display("txn correct-predict: br=%0d mis=%0d", branch_cnt_o, mispred_cnt_o);
      cyc();
      chk("ok_upd_1cyc", 64'(bus.bp_update_o), 64'd0);

      // Mispredict, not taken: redirect to fall-through
      drive_branch(1'b1, 1'b0, 32'h0000_0200, 32'h0000_0104);
      cyc();
      bus.br_valid_i = 1'b0;
      chk("mp_upd",   64'(bus.bp_update_o),   64'd1);
      chk("mp_redir", 64'(bus.pc_redirect_o), 64'd1);
      chk("mp_rpc",   64'(bus.redirect_pc_o), 64'h104);
      chk("mp_flush", 64'(bus.flush_o),       64'd1);
      chk("mp_busy",  64'(bus.busy_o),        64'd1);
      chk_cnts("mp");
      cyc();
      chk("mp_f_redir", 64'(bus.pc_redirect_o), 64'd0);
      chk("mp_f_rpc",   64'(bus.redirect_pc_o), 64'd0);
      chk("mp_f_flush", 64'(bus.flush_o),       64'd1);
      chk("mp_f_busy",  64'(bus.busy_o),        64'd1);
      cyc();
      chk_idle("mp_end");
      $display("txn mispredict: br=%0d mis=%0d", branch_cnt_o, mispred_cnt_o);

      // Branch held in EX by a stall is only taken once the stall drops
      bus.br_valid_i = 1'b1;
      bus.br_pred_i  = 1'b0;
      bus.br_taken_i = 1'b0;
      bus.stall_i    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("st_no_upd", 64'(bus.bp_update_o), 64'd0);
      end
      bus.stall_i = 1'b0;
      drive_branch(1'b0, 1'b0, 32'h0000_0400, 32'h0000_0108);
      cyc();
      bus.br_valid_i = 1'b0;
      chk("st_upd", 64'(bus.bp_update_o), 64'd1);
      chk_cnts("st");
      $display("txn stalled-branch: br=%0d mis=%0d", branch_cnt_o, mispred_cnt_o);

      // Mispredict, taken, with a 4-cycle stall while redirecting
      drive_branch(1'b0, 1'b1, 32'h0000_0300, 32'h0000_010c);
      cyc();
      bus.br_valid_i = 1'b0;
      bus.stall_i    = 1'b1;
      chk("sr_redir0", 64'(bus.pc_redirect_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("sr_redir_hold", 64'(bus.pc_redirect_o), 64'd1);
         chk("sr_rpc_hold",   64'(bus.redirect_pc_o), 64'h300);
         chk("sr_flush_hold", 64'(bus.flush_o),       64'd1);
      end
      bus.stall_i = 1'b0;
      cyc();
      chk("sr_f_redir", 64'(bus.pc_redirect_o), 64'd0);
      chk("sr_f_flush", 64'(bus.flush_o),       64'd1);
      cyc();
      chk_idle("sr_end");
      chk_cnts("sr");
      $display("txn stalled-redirect: br=%0d mis=%0d", branch_cnt_o, mispred_cnt_o);

      // Wrong-path branches during REDIRECT and FLUSH are ignored
      drive_branch(1'b1, 1'b0, 32'h0000_0500, 32'h0000_0110);
      cyc();
      bus.br_pred_i  = 1'b0;
      bus.br_taken_i = 1'b1;
      cyc();
      chk("wp_upd_redir", 64'(bus.bp_update_o), 64'd0);
      cyc();
      bus.br_valid_i = 1'b0;
      chk("wp_upd_flush", 64'(bus.bp_update_o), 64'd0);
      chk_idle("wp_end");
      chk_cnts("wp");
      $display("txn wrong-path: br=%0d mis=%0d", branch_cnt_o, mispred_cnt_o);

      // Drive both counters into saturation
      for (int i = 0; i < int'(CNT_MAX) + 5; i++) begin
         drive_branch(1'b1, 1'b0, 32'h0000_0600, 32'h0000_0114);
         cyc();
         bus.br_valid_i = 1'b0;
         cyc();
         cyc();
      end
      chk_cnts("sat_mis");
      for (int i = 0; i < 5; i++) begin
         drive_branch(1'b1, 1'b1, 32'h0000_0700, 32'h0000_0118);
         cyc();
      end
      bus.br_valid_i = 1'b0;
      chk("sat_br_max",  64'(branch_cnt_o),  64'(CNT_MAX));
      chk("sat_mis_max", 64'(mispred_cnt_o), 64'(CNT_MAX));
      $display("txn saturate: br=%0d mis=%0d", branch_cnt_o, mispred_cnt_o);

      // Clear wins over a simultaneous accepted mispredict
      drive_branch(1'b0, 1'b1, 32'h0000_0800, 32'h0000_011c);
      clr_cnt_i = 1'b1;
      exp_br  = 0;
      exp_mis = 0;
      cyc();
      bus.br_valid_i = 1'b0;
      clr_cnt_i      = 1'b0;
      chk_cnts("clr");
      cyc();
      cyc();
      drive_branch(1'b1, 1'b1, 32'h0000_0900, 32'h0000_0120);
      cyc();
      bus.br_valid_i = 1'b0;
      chk_cnts("clr_after");
      $display("txn clear: br=%0d mis=%0d", branch_cnt_o, mispred_cnt_o);

      // Reset asserted in REDIRECT clears everything without waiting for a clock
      drive_branch(1'b1, 1'b0, 32'h0000_0a00, 32'h0000_0124);
      cyc();
      bus.br_valid_i = 1'b0;
      chk("rr_redir", 64'(bus.pc_redirect_o), 64'd1);
      @(negedge clk);
      #1;
      rst_i = 1'b0;
      exp_br  = 0;
      exp_mis = 0;
      #1;
      chk_idle("rr");
      chk("rr_upd", 64'(bus.bp_update_o), 64'd0);
      chk_cnts("rr");
      cyc();
      rst_i = 1'b1;
      drive_branch(1'b0, 1'b0, 32'h0000_0b00, 32'h0000_0128);
      cyc();
      bus.br_valid_i = 1'b0;
      chk("rr_new_upd", 64'(bus.bp_update_o), 64'd1);
      chk_idle("rr_new");
      chk_cnts("rr_new");
      $display("txn reset-in-redirect: br=%0d mis=%0d", branch_cnt_o, mispred_cnt_o);

      cyc();
      cyc();
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_update_ctrl.md
BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/target width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-003 SHALL have port clk_i  input  1  the single clock, rising-edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port br_valid_i  input  1  conditional branch resolving in EX this cycle.
REQ-006 SHALL have port br_taken_i  input  1  actual branch decision.
REQ-007 SHALL have port br_pred_i  input  1  prediction carried with the instruction.
REQ-008 SHALL have port stall_i  input  1  pipeline stall (memory miss).
REQ-009 SHALL have port clr_cnt_i  input  1  synchronous statistics clear.
REQ-010 SHALL have port ttarget_i  input  XLEN  taken target.
REQ-011 SHALL have port nttarget_i  input  XLEN  fall-through PC.
REQ-012 SHALL have port bp_update_o  output  1  update strobe to predictor.
REQ-013 SHALL have port bp_actual_o  output  1  actual decision to predictor.
REQ-014 SHALL have port pc_redirect_o  output  1  fetch PC override.
REQ-015 SHALL have port redirect_pc_o  output  XLEN  corrected PC.
REQ-016 SHALL have port flush_o  output  1  kill IF/ID contents.
REQ-017 SHALL have port busy_o  output  1  state not IDLE.
REQ-018 SHALL have port branch_cnt_o  output  CNT_W  accepted branches.
REQ-019 SHALL have port mispred_cnt_o  output  CNT_W  mispredicted branches.

Function
REQ-020 SHALL implement states IDLE, REDIRECT, FLUSH; all outputs registered.
REQ-021 SHALL accept a branch only in IDLE with br_valid_i=1 and stall_i=0; br_valid_i during stall_i=1 is not accepted (branch remains in EX, re-presented).
REQ-022 On acceptance SHALL, next cycle, assert bp_update_o for exactly one cycle with bp_actual_o=captured br_taken_i; exactly one update per accepted branch.
REQ-023 On acceptance SHALL capture mispredict = (br_pred_i != br_taken_i) and redirect PC = br_taken_i ? ttarget_i : nttarget_i.
REQ-024 Accepted correct prediction SHALL leave state IDLE; no redirect, no flush.
REQ-025 Accepted mispredict SHALL enter REDIRECT next cycle: pc_redirect_o=1, flush_o=1, redirect_pc_o=captured PC.
REQ-026 REDIRECT SHALL hold all its outputs while stall_i=1; on a cycle with stall_i=0 SHALL go to FLUSH.
REQ-027 FLUSH SHALL last one cycle: flush_o=1, pc_redirect_o=0, then IDLE.
REQ-028 br_valid_i in REDIRECT or FLUSH SHALL be ignored (wrong-path), with no update and no count.
REQ-029 branch_cnt_o SHALL increment per accepted branch; mispred_cnt_o per accepted mispredict; both saturate at all-ones.
REQ-030 clr_cnt_i SHALL zero both counters next cycle and win over a simultaneous increment.
REQ-031 redirect_pc_o SHALL be 0 whenever pc_redirect_o=0.
REQ-032 busy_o SHALL be 1 exactly in REDIRECT and FLUSH.

Reset
REQ-033 rst_i=0 SHALL immediately force IDLE, all outputs 0, counters 0, including mid-REDIRECT/FLUSH; a pending update or redirect is discarded.
REQ-034 The first acceptance SHALL be possible on the first rising edge after rst_i deasserts.

Structure
REQ-035 State encoding enum, XLEN and CNT_W defaults SHALL live in shared package bp_pkg.
REQ-036 Statistics counters SHALL use one sub-module, sat_counter (width parameter, inc, clr, saturating), instantiated twice.

Verification
REQ-037 Correct prediction: br_valid_i=1, pred=1, taken=1 -> next cycle bp_update_o=1, bp_actual_o=1, no flush, branch_cnt_o=1, mispred_cnt_o=0.
REQ-038 Mispredict: pred=1, taken=0, nttarget_i=0x0000_0104 -> update pulse; REDIRECT with redirect_pc_o=0x104, flush 2 cycles, busy_o 2 cycles, mispred_cnt_o=1.
REQ-039 Stall: br_valid_i=1 with stall_i=1 for 3 cycles, then 0 -> exactly one bp_update_o, after stall drops; mispredict with stall_i=1 for 4 cycles in REDIRECT -> pc_redirect_o held 5 cycles.
REQ-040 Wrong-path: br_valid_i=1 during REDIRECT and FLUSH -> no update, counts unchanged.
REQ-041 Saturation/clear: counters preloaded to 0xFFFF with further branches -> stay 0xFFFF; clr_cnt_i with simultaneous branch -> both 0.
REQ-042 Reset in REDIRECT: rst_i=0 -> all outputs 0 immediately; after release, new branch is accepted normally.
